// File: rtl/wifi_pio_pkg.sv
// rtl/wifi_pio_pkg.sv - shared register map and edge-type constants for the PIO blocks
package wifi_pio_pkg;

   // Register addresses on the Avalon-MM slave
   localparam logic [1:0] PIO_ADDR_DATA = 2'd0;
   localparam logic [1:0] PIO_ADDR_DIR  = 2'd1;
   localparam logic [1:0] PIO_ADDR_MASK = 2'd2;
   localparam logic [1:0] PIO_ADDR_EDGE = 2'd3;

   // Captured edge selection
   localparam int EDGE_RISE = 0;
   localparam int EDGE_FALL = 1;
   localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/wifi_pio_sync_edge.sv
// rtl/wifi_pio_sync_edge.sv - per-bus input synchronizer, one-cycle delay and edge detector
module wifi_pio_sync_edge
   import wifi_pio_pkg::*;
#(
   parameter int WIDTH       = 32,
   parameter int SYNC_STAGES = 2,
   parameter int EDGE_TYPE   = EDGE_RISE
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] async_i,
   output logic [WIDTH-1:0] sync_o,
   output logic [WIDTH-1:0] edge_o
);

   logic [WIDTH-1:0] stage_q [SYNC_STAGES];
   logic [WIDTH-1:0] prev_q;

   // Shift the raw inputs through the synchronizer chain and keep the previous synced value
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            stage_q[i] <= '0;
         end
         prev_q <= '0;
      end else begin
         stage_q[0] <= async_i;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            stage_q[i] <= stage_q[i-1];
         end
         prev_q <= stage_q[SYNC_STAGES-1];
      end
   end

   assign sync_o = stage_q[SYNC_STAGES-1];

   // Compare the synced value against its one-cycle-old copy for the selected edge kind
   always_comb begin
      edge_o = '0;
      case (EDGE_TYPE)
         EDGE_RISE: edge_o = stage_q[SYNC_STAGES-1] & ~prev_q;
         EDGE_FALL: edge_o = ~stage_q[SYNC_STAGES-1] & prev_q;
         default:   edge_o = stage_q[SYNC_STAGES-1] ^ prev_q;
      endcase
   end

endmodule

// File: rtl/wifi_pio_in.sv
// rtl/wifi_pio_in.sv - Avalon-MM input PIO with edge capture; define WIFI_PIO_IN_IRQ_EN for irq_mask and irq
module wifi_pio_in
   import wifi_pio_pkg::*;
#(
   parameter int WIDTH       = 32,
   parameter int EDGE_TYPE   = EDGE_RISE,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             read_n,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   input  logic [WIDTH-1:0] in_port,
   output logic [31:0]      readdata,
   output logic             irq
);

   // Edge detection stays off until prev has seen a real synced value, so inputs
   // already high when reset releases never look like edges.
   localparam logic [2:0] PRIME_CYCLES = 3'(SYNC_STAGES + 1);

   logic [WIDTH-1:0] sync_w;
   logic [WIDTH-1:0] edge_w;
   logic [2:0]       prime_q;
   logic             primed_w;
   logic             wr_en_w;
   logic             rd_en_w;
   logic [WIDTH-1:0] clr_w;
   logic [WIDTH-1:0] cap_q;
   logic [WIDTH-1:0] cap_d;
   logic [31:0]      readdata_q;
   logic [31:0]      readdata_d;

   wifi_pio_sync_edge #(
      .WIDTH       (WIDTH),
      .SYNC_STAGES (SYNC_STAGES),
      .EDGE_TYPE   (EDGE_TYPE)
   ) u_sync_edge (
      .clk     (clk),
      .reset_n (reset_n),
      .async_i (in_port),
      .sync_o  (sync_w),
      .edge_o  (edge_w)
   );

   assign primed_w = (prime_q == PRIME_CYCLES);
   assign wr_en_w  = chipselect & ~write_n;
   assign rd_en_w  = chipselect & ~read_n;
   assign clr_w    = (wr_en_w && address == PIO_ADDR_EDGE) ? writedata[WIDTH-1:0] : '0;

   // Count cycles since reset release and saturate once edges may be trusted
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         prime_q <= '0;
      end else if (!primed_w) begin
         prime_q <= prime_q + 3'd1;
      end
   end

   // New edges are ORed in after the clear so a same-cycle set beats the clear
   always_comb begin
      cap_d = (cap_q & ~clr_w) | (primed_w ? edge_w : '0);
   end

   // Sticky capture register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cap_q <= '0;
      end else begin
         cap_q <= cap_d;
      end
   end

`ifdef WIFI_PIO_IN_IRQ_EN
   logic [WIDTH-1:0] mask_q;

   // Interrupt mask register, plain read/write
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mask_q <= '0;
      end else if (wr_en_w && address == PIO_ADDR_MASK) begin
         mask_q <= writedata[WIDTH-1:0];
      end
   end

   assign irq = |(cap_q & mask_q);
`else
   assign irq = 1'b0;
`endif

   // Select the addressed register on a read strobe, zero otherwise
   always_comb begin
      readdata_d = '0;
      if (rd_en_w) begin
         case (address)
            PIO_ADDR_DATA: readdata_d[WIDTH-1:0] = sync_w;
            PIO_ADDR_DIR:  readdata_d = '0;
`ifdef WIFI_PIO_IN_IRQ_EN
            PIO_ADDR_MASK: readdata_d[WIDTH-1:0] = mask_q;
`else
            PIO_ADDR_MASK: readdata_d = '0;
`endif
            PIO_ADDR_EDGE: readdata_d[WIDTH-1:0] = cap_q;
            default:       readdata_d = '0;
         endcase
      end
   end

   // Read-latency-1 output register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         readdata_q <= '0;
      end else begin
         readdata_q <= readdata_d;
      end
   end

   assign readdata = readdata_q;

endmodule

// File: tb/tb_wifi_pio_in.sv
// tb/tb_wifi_pio_in.sv - bench for wifi_pio_in, three parameter sets against a sample-history model
module tb_wifi_pio_in;
   import wifi_pio_pkg::*;

`ifdef WIFI_PIO_IN_IRQ_EN
   localparam bit IRQ_EN = 1'b1;
`else
   localparam bit IRQ_EN = 1'b0;
`endif

   localparam int NI = 3;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [1:0]  address = '0;
   logic        chipselect = 1'b0;
   logic        read_n = 1'b1;
   logic        write_n = 1'b1;
   logic [31:0] writedata = '0;
   logic [31:0] in_port = '0;
   logic [31:0] rdo [NI];
   logic        irqo [NI];

   int checks = 0;
   int errors = 0;

   wifi_pio_in #(.WIDTH(32), .EDGE_TYPE(EDGE_RISE), .SYNC_STAGES(2)) u_dut0 (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .read_n(read_n), .write_n(write_n), .writedata(writedata),
      .in_port(in_port), .readdata(rdo[0]), .irq(irqo[0]));

   wifi_pio_in #(.WIDTH(8), .EDGE_TYPE(EDGE_FALL), .SYNC_STAGES(3)) u_dut1 (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .read_n(read_n), .write_n(write_n), .writedata(writedata),
      .in_port(in_port[7:0]), .readdata(rdo[1]), .irq(irqo[1]));

   wifi_pio_in #(.WIDTH(5), .EDGE_TYPE(EDGE_ANY), .SYNC_STAGES(4)) u_dut2 (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .read_n(read_n), .write_n(write_n), .writedata(writedata),
      .in_port(in_port[4:0]), .readdata(rdo[2]), .irq(irqo[2]));

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic int wid(input int i);
      case (i)
         0: return 32;
         1: return 8;
         default: return 5;
      endcase
   endfunction

   function automatic int nsync(input int i);
      case (i)
         0: return 2;
         1: return 3;
         default: return 4;
      endcase
   endfunction

   function automatic int etype(input int i);
      case (i)
         0: return EDGE_RISE;
         1: return EDGE_FALL;
         default: return EDGE_ANY;
      endcase
   endfunction

   function automatic logic [31:0] wmask(input int i);
      logic [31:0] m;
      m = '1;
      return m >> (32 - wid(i));
   endfunction

   // Model: every in_port value sampled on a clock edge since reset release, in order.
   // A change between two post-release samples at edges k-1 and k is captured at edge k+N;
   // the value sampled at edge k is readable from a read issued at edge k+N.
   logic [31:0] hq [$];
   int          t;
   logic [31:0] m_cap  [NI];
   logic [31:0] m_mask [NI];
   logic [31:0] m_rd   [NI];
   logic        m_irq  [NI];

   function automatic logic [31:0] samp(input int k);
      return (k >= 1) ? hq[k-1] : 32'h0;
   endfunction

   task automatic model_clear();
      t = 0;
      hq.delete();
      for (int i = 0; i < NI; i++) begin
         m_cap[i] = '0; m_mask[i] = '0; m_rd[i] = '0; m_irq[i] = 1'b0;
      end
   endtask

   task automatic step(input logic [31:0] inp, input logic cs, input logic rd,
                       input logic wr, input logic [1:0] a, input logic [31:0] wd);
      logic [31:0] msk, cur, old, set, clr;
      int          n;
      in_port = inp; chipselect = cs; read_n = ~rd; write_n = ~wr; address = a; writedata = wd;
      @(posedge clk);
      t++;
      hq.push_back(inp);
      for (int i = 0; i < NI; i++) begin
         msk = wmask(i);
         n = nsync(i);
         m_rd[i] = '0;
         if (cs && rd) begin
            case (a)
               2'd0: m_rd[i] = samp(t - n) & msk;
               2'd2: m_rd[i] = m_mask[i];
               2'd3: m_rd[i] = m_cap[i];
               default: m_rd[i] = '0;
            endcase
         end
         set = '0;
         if (t >= n + 2) begin
            cur = samp(t - n) & msk;
            old = samp(t - n - 1) & msk;
            case (etype(i))
               EDGE_RISE: set = cur & ~old;
               EDGE_FALL: set = ~cur & old & msk;
               default:   set = cur ^ old;
            endcase
         end
         clr = (cs && wr && a == 2'd3) ? (wd & msk) : '0;
         m_cap[i] = (m_cap[i] & ~clr) | set;
         if (IRQ_EN && cs && wr && a == 2'd2) m_mask[i] = wd & msk;
         m_irq[i] = |(m_cap[i] & m_mask[i]);
      end
      #1;
      for (int i = 0; i < NI; i++) begin
         check_val($sformatf("readdata%0d_t%0d", i, t), rdo[i], m_rd[i]);
         check_val($sformatf("irq%0d_t%0d", i, t), {31'h0, irqo[i]}, {31'h0, m_irq[i]});
      end
   endtask

   task automatic idle(input logic [31:0] inp, input int cnt);
      for (int k = 0; k < cnt; k++) step(inp, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0);
   endtask

   task automatic do_reset(input logic [31:0] inp);
      reset_n = 1'b0; in_port = inp; chipselect = 1'b0; read_n = 1'b1; write_n = 1'b1;
      address = '0; writedata = '0;
      repeat (2) @(posedge clk);
      #1;
      for (int i = 0; i < NI; i++) begin
         check_val($sformatf("reset_readdata%0d", i), rdo[i], 32'h0);
         check_val($sformatf("reset_irq%0d", i), {31'h0, irqo[i]}, 32'h0);
      end
      reset_n = 1'b1;
      model_clear();
   endtask

   logic [31:0] cur_in;
   int          op;
   logic [1:0]  ra;

   initial begin
      model_clear();

      // All inputs high at reset release must not produce captures
      do_reset(32'hFFFF_FFFF);
      step(32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1, 2'd2, 32'hFFFF_FFFF);
      idle(32'hFFFF_FFFF, 20);
      step(32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0, 2'd3, 32'h0);
      check_val("spurious_capture", rdo[0], 32'h0);
      step(32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0, 2'd0, 32'h0);
      check_val("data_all_ones", rdo[0], 32'hFFFF_FFFF);

      // Rising edge on bit 3 with mask 0x8, then W1C clear
      do_reset(32'h0);
      step(32'h0, 1'b1, 1'b0, 1'b1, 2'd2, 32'h8);
      idle(32'h0, 6);
      idle(32'h8, 6);
      step(32'h8, 1'b1, 1'b1, 1'b0, 2'd3, 32'h0);
      check_val("cap_bit3", rdo[0], 32'h8);
      step(32'h8, 1'b1, 1'b0, 1'b1, 2'd3, 32'h8);
      step(32'h8, 1'b1, 1'b1, 1'b0, 2'd3, 32'h0);
      check_val("cap_cleared", rdo[0], 32'h0);

      // Second rising edge lands on the same edge as a W1C write: set wins
      idle(32'h8, 4);
      idle(32'h0, 4);
      step(32'h8, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0);
      step(32'h8, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0);
      step(32'h8, 1'b1, 1'b0, 1'b1, 2'd3, 32'h8);
      step(32'h8, 1'b1, 1'b1, 1'b0, 2'd3, 32'h0);
      check_val("set_wins", rdo[0], 32'h8);

      // Masked capture on bit 0, then unmask
      step(32'h8, 1'b1, 1'b0, 1'b1, 2'd2, 32'h0);
      step(32'h8, 1'b1, 1'b0, 1'b1, 2'd3, 32'hFFFF_FFFF);
      idle(32'h9, 6);
      step(32'h9, 1'b1, 1'b1, 1'b0, 2'd3, 32'h0);
      check_val("masked_cap", rdo[0], 32'h1);
      check_val("masked_irq", {31'h0, irqo[0]}, 32'h0);
      step(32'h9, 1'b1, 1'b0, 1'b1, 2'd2, 32'h1);
      check_val("unmasked_irq", {31'h0, irqo[0]}, {31'h0, IRQ_EN});

      // Narrow instance: upper bits ignored on every register
      step(32'h9, 1'b1, 1'b0, 1'b1, 2'd1, 32'hFFFF_FFFF);
      step(32'h9, 1'b1, 1'b0, 1'b1, 2'd2, 32'hFFFF_FFFF);
      step(32'h9, 1'b1, 1'b0, 1'b1, 2'd3, 32'hFFFF_FFFF);
      step(32'h9, 1'b1, 1'b1, 1'b0, 2'd1, 32'h0);
      check_val("w8_reserved", rdo[1], 32'h0);
      step(32'h9, 1'b1, 1'b1, 1'b0, 2'd2, 32'h0);
      check_val("w8_mask", rdo[1], IRQ_EN ? 32'hFF : 32'h0);
      step(32'h9, 1'b1, 1'b1, 1'b0, 2'd3, 32'h0);
      check_val("w8_capture", rdo[1], 32'h0);

      // Asynchronous reset while irq is high and readdata holds a capture
      step(32'h9, 1'b1, 1'b0, 1'b1, 2'd2, 32'h1);
      idle(32'h8, 3);
      idle(32'h9, 6);
      step(32'h9, 1'b1, 1'b1, 1'b0, 2'd3, 32'h0);
      check_val("pre_reset_cap", rdo[0], 32'h1);
      reset_n = 1'b0;
      #1;
      check_val("async_rst_readdata", rdo[0], 32'h0);
      check_val("async_rst_irq", {31'h0, irqo[0]}, 32'h0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      model_clear();
      step(32'h9, 1'b1, 1'b1, 1'b0, 2'd3, 32'h0);
      check_val("post_reset_cap", rdo[0], 32'h0);

      // Randomized traffic against the model
      cur_in = 32'h9;
      for (int k = 0; k < 3000; k++) begin
         if ($urandom_range(0, 599) == 0) begin
            cur_in = $urandom;
            do_reset(cur_in);
         end
         cur_in = cur_in ^ ($urandom & $urandom & $urandom);
         op = $urandom_range(0, 4);
         ra = 2'($urandom_range(0, 3));
         case (op)
            0: step(cur_in, 1'b0, 1'b0, 1'b0, ra, $urandom);
            1, 2: step(cur_in, 1'b1, 1'b1, 1'b0, ra, $urandom);
            3: step(cur_in, 1'b1, 1'b0, 1'b1, ra, $urandom);
            default: step(cur_in, 1'b0, 1'b1, 1'b1, ra, $urandom);
         endcase
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/wifi_pio_in.md
# wifi_pio_in

Avalon-MM slave input port with edge capture and interrupt: the read-side companion to the system's output PIO. External signals (button, radio-module status, ready lines) are synchronized into `clk`. Their level is exposed to the Nios II, and selected edges are latched into a write-1-to-clear capture register that can raise a maskable `irq`. It sits on the system interconnect as a read-latency-1 slave alongside the output PIO.

## Interface
Parameters:
- `WIDTH`, 32: number of input bits, 1..32.
- `EDGE_TYPE`, 0: captured edge; 0 = rising, 1 = falling, 2 = any.
- `SYNC_STAGES`, 2: synchronizer depth, 2..4.

Ports:
- `clk`  in  1  clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `address`  in  2  register select.
- `chipselect`  in  1  slave select.
- `read_n`  in  1  active-low read strobe.
- `write_n`  in  1  active-low write strobe.
- `writedata`  in  32  write data.
- `in_port`  in  WIDTH  asynchronous external inputs.
- `readdata`  out  32  registered read data.
- `irq`  out  1  active-high level interrupt.

## Operation
- Register map:
  - Address 0, data: read-only; reads the synchronized `in_port`.
  - Address 1, reserved: reads 0; writes ignored.
  - Address 2, irq_mask: R/W; reset value 0.
  - Address 3, edge_capture: R/W1C; reset value 0.
- Bits at or above `WIDTH` read 0 in every register; writes to those bits are ignored.
- Synchronizer: `SYNC_STAGES` flops per bit, all reset to 0. `sync` is the output of the last stage. `prev` is `sync` delayed by one cycle, reset to 0.
- Edge detect per bit:
  - Rising: `sync & ~prev`.
  - Falling: `~sync & prev`.
  - Any: `sync ^ prev`.
- Prime counter: after reset release, edge detection is disabled for `SYNC_STAGES`+1 cycles. Inputs already high at release therefore never produce a spurious capture.
- Capture bit: set on a detected edge and sticky until cleared.
  - Clear: write to address 3 (`chipselect` & ~`write_n`) with a 1 in that bit position.
  - A 0 in the written bit position leaves the capture bit unchanged.
  - Set and clear on the same cycle: set wins.
- `irq` = OR over (edge_capture & irq_mask), decoded directly from registers with no further flop.
- Read: on a clock edge with `chipselect` & ~`read_n`, `readdata` loads the addressed register. In all other cycles `readdata` loads 0.
- Reads have no side effects; in particular, reading edge_capture does not clear it.
- Reset mid-operation: all registers clear asynchronously, `irq` and `readdata` go to 0 immediately, and the prime counter restarts.

## Timing
- Reset values: `readdata` = 0, `irq` = 0, all internal registers = 0.
- Read latency: 1 cycle. Data for a read sampled at edge j is valid after edge j.
- Input to data path: an `in_port` change set up before edge k is visible in `sync` after edge k+`SYNC_STAGES`-1. A read sampled at edge k+`SYNC_STAGES` returns the new value.
- Input to capture and interrupt: the capture bit sets at edge k+`SYNC_STAGES`. If the bit is unmasked, `irq` is high in the cycle following that edge.
- Clear: a W1C write at edge m clears the bit at edge m. `irq` drops after edge m unless another unmasked capture bit remains set.
- Mask: a mask write at edge m affects `irq` after edge m.
- Input pulses shorter than one `clk` period may be missed; no capture is guaranteed for them.

## Configuration
- `WIFI_PIO_IN_IRQ_EN` defined: the irq_mask register is implemented and `irq` is driven as described above.
- `WIFI_PIO_IN_IRQ_EN` undefined:
  - irq_mask is not implemented; address 2 reads 0 and writes to it are ignored.
  - `irq` is tied to 0.
  - The edge_capture register and its W1C behaviour remain present.

## Structure
- Shared package `wifi_pio_pkg` holds:
  - Address constants `PIO_ADDR_DATA`=0, `PIO_ADDR_DIR`=1, `PIO_ADDR_MASK`=2, `PIO_ADDR_EDGE`=3.
  - Edge-type constants `EDGE_RISE`, `EDGE_FALL`, `EDGE_ANY`.
- One sub-module, `wifi_pio_sync_edge`: a per-bus synchronizer plus `prev` register plus edge detector, parameterized by `WIDTH`, `SYNC_STAGES` and `EDGE_TYPE`.
- The top level contains the prime counter, capture and mask registers, read mux and `irq` logic.

## Test plan
- Reset release with `in_port`=0xFFFFFFFF, `EDGE_TYPE`=0 -> edge_capture reads 0 and `irq` stays 0 for 20 cycles; address 0 reads 0xFFFFFFFF.
- `in_port` bit 3 goes 0->1, mask=0x8 -> capture reads 0x8 and `irq` rises `SYNC_STAGES` edges later; write 0x8 to address 3 -> `irq` falls and capture reads 0.
- A second rising edge on bit 3 lands in the same cycle as a W1C write of 0x8 -> capture remains 0x8 and `irq` stays high.
- Mask=0, edge on bit 0 -> capture=0x1 and `irq`=0; then write mask=0x1 -> `irq`=1 after that edge.
- `WIDTH`=8, write 0xFFFFFFFF to addresses 1, 2 and 3 -> reads return 0, 0xFF (0 without `WIFI_PIO_IN_IRQ_EN`), and 0 respectively.
- Assert `reset_n` while `irq`=1 and a capture bit is set -> `irq` and `readdata` go to 0 asynchronously; after release, capture reads 0.
